// File: rtl/worley_anim_pkg.sv
// Shared types and constants for the Worley feature-point animator.
package worley_anim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_X  = 2'd1,
    UPD_Y  = 2'd2,
    COMMIT = 2'd3
  } anim_state_e;

  localparam int DEF_H_MAX = 639;
  localparam int DEF_V_MAX = 479;

  // Start-of-day table for four points; larger configurations wrap modulo 4.
  localparam int INIT_X  [4] = '{100, 300, 500, 100};
  localparam int INIT_Y  [4] = '{100, 200, 400, 460};
  localparam int INIT_VX [4] = '{  1,  -1,   1,  -1};
  localparam int INIT_VY [4] = '{ -1,   1,  -1,  -1};

endpackage

// File: rtl/worley_axis_step.sv
// One axis step: advance a coordinate by (velocity << speed), bouncing off 0 and max.
module worley_axis_step #(
  parameter int COORD_W = 10,
  parameter int VEL_W   = 3
) (
  input  logic [COORD_W-1:0] p,
  input  logic [VEL_W-1:0]   v,
  input  logic [1:0]         speed,
  input  logic [COORD_W-1:0] max,
  output logic [COORD_W-1:0] p_next,
  output logic [VEL_W-1:0]   v_next
);

  // Wide enough that p + d and 2*max - n never overflow.
  localparam int SW = COORD_W + VEL_W + 3;

  logic signed [SW-1:0] p_s, m_s, d, n, r;

  // Add the scaled velocity, then reflect any overshoot back inside [0, max].
  always_comb begin
    p_s    = signed'({{(SW-COORD_W){1'b0}}, p});
    m_s    = signed'({{(SW-COORD_W){1'b0}}, max});
    d      = signed'({{(SW-VEL_W){v[VEL_W-1]}}, v}) <<< speed;
    n      = p_s + d;
    r      = n;
    v_next = v;
    if (n < 0) begin
      r      = -n;
      v_next = ~v + VEL_W'(1);
    end else if (n > m_s) begin
      r      = (m_s <<< 1) - n;
      v_next = ~v + VEL_W'(1);
    end
    p_next = COORD_W'(r);
  end

endmodule

// File: rtl/worley_point_animator.sv
// Per-frame sequencer: walks every point through one shared axis step, X then Y,
// and publishes the whole working set in a single edge so the noise generator
// never sees a half-updated frame.
module worley_point_animator
  import worley_anim_pkg::*;
#(
  parameter int NUM_POINTS = 4,
  parameter int COORD_W    = 10,
  parameter int H_MAX      = DEF_H_MAX,
  parameter int V_MAX      = DEF_V_MAX,
  parameter int VEL_W      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          freeze,
  input  logic [1:0]                    speed,
  output logic [NUM_POINTS*COORD_W-1:0] pts_x,
  output logic [NUM_POINTS*COORD_W-1:0] pts_y,
  output logic                          busy,
  output logic                          update_done
);

  localparam int IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_POINTS - 1);

  anim_state_e      state;
  logic [IDX_W-1:0] idx;

  // Working copies, rewritten one axis per cycle during the sequence.
  logic [NUM_POINTS-1:0][COORD_W-1:0] wx, wy;
  logic [NUM_POINTS-1:0][VEL_W-1:0]   vx, vy;

  logic [COORD_W-1:0] ax_p, ax_max, ax_p_next;
  logic [VEL_W-1:0]   ax_v, ax_v_next;
  logic               is_y;

  // Steer the selected point's X or Y into the single shared step unit.
  always_comb begin
    is_y   = (state == UPD_Y);
    ax_p   = is_y ? wy[idx] : wx[idx];
    ax_v   = is_y ? vy[idx] : vx[idx];
    ax_max = is_y ? COORD_W'(V_MAX) : COORD_W'(H_MAX);
  end

  worley_axis_step #(
    .COORD_W (COORD_W),
    .VEL_W   (VEL_W)
  ) u_step (
    .p      (ax_p),
    .v      (ax_v),
    .speed  (speed),
    .max    (ax_max),
    .p_next (ax_p_next),
    .v_next (ax_v_next)
  );

  // Sequencer FSM plus working/published state; outputs move only on COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      for (int i = 0; i < NUM_POINTS; i++) begin
        wx[i]                       <= COORD_W'(INIT_X[i % 4]);
        wy[i]                       <= COORD_W'(INIT_Y[i % 4]);
        vx[i]                       <= VEL_W'(INIT_VX[i % 4]);
        vy[i]                       <= VEL_W'(INIT_VY[i % 4]);
        pts_x[i*COORD_W +: COORD_W] <= COORD_W'(INIT_X[i % 4]);
        pts_y[i*COORD_W +: COORD_W] <= COORD_W'(INIT_Y[i % 4]);
      end
    end else begin
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && !freeze) begin
            state <= UPD_X;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPD_X: begin
          wx[idx] <= ax_p_next;
          vx[idx] <= ax_v_next;
          state   <= UPD_Y;
        end
        UPD_Y: begin
          wy[idx] <= ax_p_next;
          vy[idx] <= ax_v_next;
          if (idx == LAST_IDX) begin
            state <= COMMIT;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= UPD_X;
          end
        end
        COMMIT: begin
          pts_x       <= wx;
          pts_y       <= wy;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_worley_point_animator.sv
// Bench for worley_point_animator: directed scenarios plus a random run, all
// checked against a frame-level model of point motion with bouncing edges.
module tb_worley_point_animator;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int VW = 3;
  localparam int HM = 639;
  localparam int VM = 479;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          freeze = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic [N*CW-1:0] pts_x, pts_y;
  logic          busy, update_done;

  worley_point_animator #(
    .NUM_POINTS (N),
    .COORD_W    (CW),
    .H_MAX      (HM),
    .V_MAX      (VM),
    .VEL_W      (VW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .freeze      (freeze),
    .speed       (speed),
    .pts_x       (pts_x),
    .pts_y       (pts_y),
    .busy        (busy),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int IX [4] = '{100, 300, 500, 100};
  int IY [4] = '{100, 200, 400, 460};
  int IVX[4] = '{  1,  -1,   1,  -1};
  int IVY[4] = '{ -1,   1,  -1,  -1};

  // Model: positions advance a whole frame at acceptance, become visible at commit.
  int mx[N], my[N], mvx[N], mvy[N], px[N], py[N];
  int m_cnt;
  bit m_done;

  function automatic void step(input int p, input int v, input int sp, input int mx_,
                               output int pn, output int vn);
    int n;
    n  = p + v * (1 << sp);
    pn = n;
    vn = v;
    if (n < 0) begin
      pn = -n; vn = -v;
    end else if (n > mx_) begin
      pn = 2 * mx_ - n; vn = -v;
    end
  endfunction

  function automatic logic [N*CW-1:0] pack(input int a[N]);
    logic [N*CW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(a[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = IX[i % 4]; my[i] = IY[i % 4];
      mvx[i] = IVX[i % 4]; mvy[i] = IVY[i % 4];
      px[i] = mx[i]; py[i] = my[i];
    end
    m_cnt  = 0;
    m_done = 0;
  endtask

  task automatic model_frame(input int sp);
    int pn, vn;
    for (int i = 0; i < N; i++) begin
      step(mx[i], mvx[i], sp, HM, pn, vn); mx[i] = pn; mvx[i] = vn;
      step(my[i], mvy[i], sp, VM, pn, vn); my[i] = pn; mvy[i] = vn;
    end
  endtask

  // One clock: drive inputs (caller is at a negedge), advance the model at the
  // edge, and return at the following negedge ready for sampling.
  task automatic tick(input logic fs, input logic fr);
    frame_start = fs;
    freeze      = fr;
    @(posedge clk);
    m_done = 0;
    if (m_cnt == 0) begin
      if (fs && !fr) begin
        m_cnt = 2 * N + 1;
        model_frame(int'(speed));
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1;
        for (int i = 0; i < N; i++) begin px[i] = mx[i]; py[i] = my[i]; end
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    freeze = 1'b0;
  endtask

  // One accepted frame followed by the ticks needed to commit; counts pulses.
  task automatic run_frames(input int nf, output int dones);
    dones = 0;
    for (int f = 0; f < nf; f++) begin
      tick(1'b1, 1'b0);
      if (update_done) dones++;
      for (int t = 0; t < 9; t++) begin
        tick(1'b0, 1'b0);
        if (update_done) dones++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (update_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", update_done); end
    n_cmp++; if (pts_x !== pack(px)) begin n_bad++; $display("FAIL reset_pts_x: got %h want %h", pts_x, pack(px)); end
    n_cmp++; if (pts_y !== pack(py)) begin n_bad++; $display("FAIL reset_pts_y: got %h want %h", pts_y, pack(py)); end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int busy_cnt, done_cnt, done_at;
    logic [N*CW-1:0] ex, ey, init_x;
    do_reset();
    speed = 2'd0;
    init_x = pack(px);
    ex = {10'd99, 10'd501, 10'd299, 10'd101};
    ey = {10'd459, 10'd399, 10'd201, 10'd99};
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    tick(1'b1, 1'b0);
    if (busy) busy_cnt++;
    for (int t = 1; t <= 12; t++) begin
      tick(1'b0, 1'b0);
      if (busy) busy_cnt++;
      if (update_done) begin done_cnt++; done_at = t; end
      if (t == 8) begin
        n_cmp++; if (pts_x !== init_x) begin n_bad++; $display("FAIL early_publish: got %h want %h", pts_x, init_x); end
      end
      if (t == 9) begin
        n_cmp++; if (pts_x !== ex) begin n_bad++; $display("FAIL frame1_pts_x: got %h want %h", pts_x, ex); end
        n_cmp++; if (pts_y !== ey) begin n_bad++; $display("FAIL frame1_pts_y: got %h want %h", pts_y, ey); end
      end
    end
    n_cmp++; if (busy_cnt != 8) begin n_bad++; $display("FAIL busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (done_at != 9) begin n_bad++; $display("FAIL done_timing: got %0d want 9", done_at); end
  endtask

  task automatic test_long_run();
    int d;
    do_reset();
    speed = 2'd0;
    run_frames(100, d);
    n_cmp++; if (pts_y[0 +: CW] !== 10'd0) begin n_bad++; $display("FAIL p0y_at_100: got %0d want 0", pts_y[0 +: CW]); end
    n_cmp++; if (d != 100) begin n_bad++; $display("FAIL long_dones: got %0d want 100", d); end
    run_frames(1, d);
    n_cmp++; if (pts_y[0 +: CW] !== 10'd1) begin n_bad++; $display("FAIL p0y_at_101: got %0d want 1", pts_y[0 +: CW]); end
    run_frames(1, d);
    n_cmp++; if (pts_y[0 +: CW] !== 10'd2) begin n_bad++; $display("FAIL p0y_at_102: got %0d want 2", pts_y[0 +: CW]); end
    n_cmp++; if (pts_x !== pack(px)) begin n_bad++; $display("FAIL long_pts_x: got %h want %h", pts_x, pack(px)); end
    n_cmp++; if (pts_y !== pack(py)) begin n_bad++; $display("FAIL long_pts_y: got %h want %h", pts_y, pack(py)); end
  endtask

  task automatic test_speed3();
    int d;
    do_reset();
    speed = 2'd3;
    run_frames(13, d);
    n_cmp++; if (pts_y[0 +: CW] !== 10'd4) begin n_bad++; $display("FAIL sp3_p0y: got %0d want 4", pts_y[0 +: CW]); end
    n_cmp++; if (pts_y[3*CW +: CW] !== 10'd356) begin n_bad++; $display("FAIL sp3_p3y: got %0d want 356", pts_y[3*CW +: CW]); end
    run_frames(1, d);
    n_cmp++; if (pts_y[0 +: CW] !== 10'd12) begin n_bad++; $display("FAIL sp3_p0y_after_bounce: got %0d want 12", pts_y[0 +: CW]); end
    n_cmp++; if (pts_x !== pack(px)) begin n_bad++; $display("FAIL sp3_pts_x: got %h want %h", pts_x, pack(px)); end
  endtask

  task automatic test_back_to_back();
    int dones, pulses;
    do_reset();
    speed = 2'd3;
    dones = 0; pulses = 0;
    for (int f = 0; f < 18; f++) begin
      tick(1'b1, 1'b0); pulses++;
      if (update_done) dones++;
      for (int t = 1; t < 10; t++) begin
        if (f == 1 && t == 4) begin tick(1'b1, 1'b0); pulses++; end
        else tick(1'b0, 1'b0);
        if (update_done) dones++;
      end
    end
    n_cmp++; if (pulses != 19 || dones != 18) begin n_bad++; $display("FAIL b2b_dones: got %0d for %0d pulses want 18", dones, pulses); end
    n_cmp++; if (pts_x[2*CW +: CW] !== 10'd634) begin n_bad++; $display("FAIL b2b_p2x: got %0d want 634", pts_x[2*CW +: CW]); end
    n_cmp++; if (pts_x !== pack(px)) begin n_bad++; $display("FAIL b2b_pts_x: got %h want %h", pts_x, pack(px)); end
    n_cmp++; if (pts_y !== pack(py)) begin n_bad++; $display("FAIL b2b_pts_y: got %h want %h", pts_y, pack(py)); end
  endtask

  task automatic test_freeze();
    int dones, busy_seen;
    logic [N*CW-1:0] ix;
    do_reset();
    speed = 2'd1;
    ix = pack(px);
    busy_seen = 0; dones = 0;
    tick(1'b1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      if (busy) busy_seen++;
      if (update_done) dones++;
      tick(1'b0, 1'b1);
    end
    n_cmp++; if (busy_seen != 0 || dones != 0) begin n_bad++; $display("FAIL freeze_blocked: got busy %0d done %0d want 0 0", busy_seen, dones); end
    n_cmp++; if (pts_x !== ix) begin n_bad++; $display("FAIL freeze_pts: got %h want %h", pts_x, ix); end
    tick(1'b1, 1'b0);
    for (int t = 0; t < 3; t++) tick(1'b0, 1'b0);
    dones = 0;
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 1'b1);
      if (update_done) dones++;
    end
    freeze = 1'b0;
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL freeze_mid_commit: got %0d want 1", dones); end
    n_cmp++; if (pts_x !== pack(px)) begin n_bad++; $display("FAIL freeze_mid_pts_x: got %h want %h", pts_x, pack(px)); end
  endtask

  task automatic test_async_reset();
    int dones;
    do_reset();
    speed = 2'd2;
    tick(1'b1, 1'b0);
    for (int t = 0; t < 4; t++) tick(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_cmp++; if (pts_x !== pack(px) || pts_y !== pack(py)) begin n_bad++; $display("FAIL arst_pts: got %h/%h want %h/%h", pts_x, pts_y, pack(px), pack(py)); end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int t = 0; t < 15; t++) begin
      tick(1'b0, 1'b0);
      if (update_done) dones++;
    end
    n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL arst_no_done: got %0d want 0", dones); end
    run_frames(1, dones);
    n_cmp++; if (pts_x !== pack(px) || pts_y !== pack(py)) begin n_bad++; $display("FAIL arst_restart: got %h/%h want %h/%h", pts_x, pts_y, pack(px), pack(py)); end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      if (m_cnt == 0 && ($urandom % 6) == 0) speed = 2'($urandom % 4);
      tick(1'(($urandom % 3) == 0), 1'(($urandom % 5) == 0));
      n_cmp++;
      if (busy !== (m_cnt >= 2) || update_done !== m_done ||
          pts_x !== pack(px) || pts_y !== pack(py)) begin
        n_bad++;
        if (errs < 5) $display("FAIL random_cycle%0d: got busy %b done %b x %h y %h want busy %b done %b x %h y %h",
                               c, busy, update_done, pts_x, pts_y, (m_cnt >= 2), m_done, pack(px), pack(py));
        errs++;
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_long_run();
    test_speed3();
    test_back_to_back();
    test_freeze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
